branch_predict_buffer: RTL and testbench

Parametrised branch target buffer with per-entry 2-bit saturating direction counters. It is the successor to the fixed 4-entry, valid/tag-only branch buffer.
- IF stage: combinational lookup by fetch PC, returning hit, predicted direction and target.
- MEM stage: registered update with the resolved branch outcome.
- Adds configurable depth, hysteresis-based direction prediction, and a bulk flush.

---
 rtl/branch_predict_buffer_pkg.sv | 16 +
 rtl/bpb_sat_counter.sv | 28 ++
 rtl/branch_predict_buffer.sv | 164 ++++++++++++++++
 tb/tb_branch_predict_buffer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/branch_predict_buffer_pkg.sv
// Shared types for the branch predict buffer: word type, 2-bit direction
// counter encoding and the counter value used when a new entry is allocated.
package branch_predict_buffer_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } bpb_cnt_t;

  localparam bpb_cnt_t BPB_CNT_INIT = WEAK_T;

endpackage

// File: rtl/bpb_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module bpb_sat_counter
  import branch_predict_buffer_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  // Step towards the resolved direction, holding at either end of the range.
  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != STRONG_T) begin
        cnt_next = cnt + 2'd1;
      end else begin
        cnt_next = cnt;
      end
    end else begin
      if (cnt != STRONG_NT) begin
        cnt_next = cnt - 2'd1;
      end else begin
        cnt_next = cnt;
      end
    end
  end

endmodule

// File: rtl/branch_predict_buffer.sv
// Branch target buffer with 2-bit saturating direction counters, combinational
// IF-stage lookup and registered MEM-stage update. Statistics under BPB_STATS_EN.
module branch_predict_buffer
  import branch_predict_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  input  logic              flush,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic       valid;
    tag_t       tag;
    word_t      target;
    logic [1:0] cnt;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [IDX_W-1:0] lk_idx_s;
  tag_t             lk_tag_s;
  logic [IDX_W-1:0] up_idx_s;
  tag_t             up_tag_s;
  logic             up_hit_s;
  logic [1:0]       up_cnt_next_s;
  logic             unused_pc_bits_s;

  assign lk_idx_s         = lookup_pc[IDX_W+1:2];
  assign lk_tag_s         = lookup_pc[31:IDX_W+2];
  assign up_idx_s         = update_pc[IDX_W+1:2];
  assign up_tag_s         = update_pc[31:IDX_W+2];
  assign up_hit_s         = ent_q[up_idx_s].valid && (ent_q[up_idx_s].tag == up_tag_s);
  assign unused_pc_bits_s = ^{lookup_pc[1:0], update_pc[1:0]};

  bpb_sat_counter u_sat_counter (
    .cnt      (ent_q[up_idx_s].cnt),
    .taken    (update_taken),
    .cnt_next (up_cnt_next_s)
  );

  // Lookup reads registered state only, so a same-cycle update is not visible.
  always_comb begin
    pred_hit    = ent_q[lk_idx_s].valid && (ent_q[lk_idx_s].tag == lk_tag_s);
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    if (pred_hit) begin
      pred_taken  = ent_q[lk_idx_s].cnt[1];
      pred_target = ent_q[lk_idx_s].target;
    end else begin
      pred_taken  = 1'b0;
      pred_target = 32'd0;
    end
  end

  // Flush overrides the update; not-taken misses never allocate.
  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
      end
    end else if (update_en) begin
      if (up_hit_s) begin
        ent_d[up_idx_s].cnt = up_cnt_next_s;
        if (update_taken) begin
          ent_d[up_idx_s].target = update_target;
        end else begin
          ent_d[up_idx_s].target = ent_q[up_idx_s].target;
        end
      end else if (update_taken) begin
        ent_d[up_idx_s].valid  = 1'b1;
        ent_d[up_idx_s].tag    = up_tag_s;
        ent_d[up_idx_s].target = update_target;
        ent_d[up_idx_s].cnt    = BPB_CNT_INIT;
      end else begin
        ent_d[up_idx_s] = ent_q[up_idx_s];
      end
    end else begin
      ent_d = ent_q;
    end
  end

  // Entry storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

`ifdef BPB_STATS_EN
  logic              up_pred_taken_s;
  logic              mispredict_s;
  logic [STAT_W-1:0] stat_updates_q;
  logic [STAT_W-1:0] stat_updates_d;
  logic [STAT_W-1:0] stat_mispredicts_q;
  logic [STAT_W-1:0] stat_mispredicts_d;

  // A correct direction with a stale target still counts as a mispredict.
  assign up_pred_taken_s = up_hit_s && ent_q[up_idx_s].cnt[1];
  assign mispredict_s    = (up_pred_taken_s != update_taken) ||
                           (up_pred_taken_s && update_taken &&
                            (ent_q[up_idx_s].target != update_target));

  // Counters wrap naturally; discarded (flushed) updates are not counted.
  always_comb begin
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (update_en && !flush) begin
      stat_updates_d = stat_updates_q + STAT_W'(1);
      if (mispredict_s) begin
        stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
      end else begin
        stat_mispredicts_d = stat_mispredicts_q;
      end
    end else begin
      stat_updates_d     = stat_updates_q;
      stat_mispredicts_d = stat_mispredicts_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_buffer.sv
// Scoreboard bench for branch_predict_buffer: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares the lookup/stat outputs.
module tb_branch_predict_buffer;

  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [31:0]   lookup_pc = 32'd0;
  logic          pred_hit;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          update_en = 1'b0;
  logic [31:0]   update_pc = 32'd0;
  logic          update_taken = 1'b0;
  logic [31:0]   update_target = 32'd0;
  logic          flush = 1'b0;
  logic [SW-1:0] stat_updates;
  logic [SW-1:0] stat_mispredicts;

  branch_predict_buffer #(.DEPTH(4), .STAT_W(SW)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .lookup_pc        (lookup_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .update_en        (update_en),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .flush            (flush),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          hit;
    logic          tk;
    logic [31:0]   tgt;
    logic [SW-1:0] su;
    logic [SW-1:0] sm;
    string         nm;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [SW-1:0] exp_upd = '0;
  logic [SW-1:0] exp_mis = '0;

  // Monitor: compare outputs mid-cycle whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pred_hit, pred_taken, pred_target, stat_updates, stat_mispredicts} !==
            {e.hit, e.tk, e.tgt, e.su, e.sm}) begin
          failures++;
          $display("FAIL %s: got hit=%0b taken=%0b target=%h upd=%0d mis=%0d, expected hit=%0b taken=%0b target=%h upd=%0d mis=%0d",
                   e.nm, pred_hit, pred_taken, pred_target, stat_updates, stat_mispredicts,
                   e.hit, e.tk, e.tgt, e.su, e.sm);
        end
      end
    end
  end

  // One cycle: drive reset/update/flush/lookup, queue the expected lookup view.
  task automatic step(input logic rst, input logic ue, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic fl,
                      input logic mp, input logic [31:0] lpc, input logic eh,
                      input logic et, input logic [31:0] etg, input string nm);
    logic [SW-1:0] su;
    logic [SW-1:0] sm;
    @(posedge CLK);
    #1;
    RST = rst; update_en = ue; update_pc = upc; update_taken = ut;
    update_target = utg; flush = fl; lookup_pc = lpc;
    if (rst) begin
      exp_upd = '0;
      exp_mis = '0;
    end
`ifdef BPB_STATS_EN
    su = exp_upd;
    sm = exp_mis;
`else
    su = '0;
    sm = '0;
`endif
    exp_q.push_back('{eh, et, etg, su, sm, nm});
    if (ue && !fl && !rst) begin
      exp_upd = exp_upd + 4'd1;
      if (mp) exp_mis = exp_mis + 4'd1;
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    //   rst   ue    upc     ut    utg      fl    mp    lpc     hit   tk    tgt
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0,   "reset_lookup");
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h100, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   "same_cycle_no_bypass");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 32'h100, "alloc_weak_t");
    step(1'b0, 1'b1, 32'h44, 1'b0, 32'h0,   1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h100, "pre_nt1");
    step(1'b0, 1'b1, 32'h44, 1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 32'h100, "weak_nt");
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h100, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, "strong_nt_sat");
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h100, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, "weak_nt_again");
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 32'h100, "weak_t_again");
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h104, 1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h100, "strong_t");
    step(1'b0, 1'b1, 32'h44, 1'b0, 32'h0,   1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h104, "strong_t_sat_new_tgt");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 32'h104, "nt_from_strong_t");
    step(1'b0, 1'b1, 32'h54, 1'b1, 32'h200, 1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h104, "pre_alias");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0,   "alias_evicted");
    step(1'b0, 1'b1, 32'h64, 1'b0, 32'h0,   1'b0, 1'b0, 32'h54, 1'b1, 1'b1, 32'h200, "alias_new");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h54, 1'b1, 1'b1, 32'h200, "nt_miss_no_alloc");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h64, 1'b0, 1'b0, 32'h0,   "nt_miss_absent");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h57, 1'b1, 1'b1, 32'h200, "low_bits_ignored");
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   "fill_idx0");
    step(1'b0, 1'b1, 32'h88, 1'b1, 32'h400, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h300, "fill_idx2");
    step(1'b0, 1'b1, 32'h4C, 1'b1, 32'h500, 1'b0, 1'b1, 32'h88, 1'b1, 1'b1, 32'h400, "fill_idx3");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h4C, 1'b1, 1'b1, 32'h500, "idx3_hit");
    step(1'b0, 1'b1, 32'h48, 1'b1, 32'h600, 1'b1, 1'b0, 32'h54, 1'b1, 1'b1, 32'h200, "pre_flush");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0,   "flush_idx0");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h54, 1'b0, 1'b0, 32'h0,   "flush_idx1");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h88, 1'b0, 1'b0, 32'h0,   "flush_idx2");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h4C, 1'b0, 1'b0, 32'h0,   "flush_idx3");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h48, 1'b0, 1'b0, 32'h0,   "flush_wins_update");
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h700, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   "realloc_pre");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 32'h700, "realloc_post");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h44, 1'b1, 32'h700, 1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 32'h700, "stat_wrap_run");
    end
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 32'h700, "stat_wrapped");
    step(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0,   "async_reset");
    step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0,   "after_reset");
    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
